// File: rtl/led_counter_pkg.sv
// Shared defaults and helpers for the LED counter block.
package led_counter_pkg;
  localparam int LC_WIDTH   = 4;
  localparam int LC_MODULUS = 16;
  localparam int LC_DIV     = 1;

  // Register width for a 0..v-1 count; never narrower than one bit.
  function automatic int clog2_min1(input int v);
    return (v < 2) ? 1 : $clog2(v);
  endfunction
endpackage

// File: rtl/led_prescaler.sv
// Divide-by-DIV tick generator; tick is high once every DIV clocks.
module led_prescaler
  import led_counter_pkg::*;
#(
  parameter int DIV = LC_DIV
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  localparam int PW = clog2_min1(DIV);
  localparam logic [PW-1:0] PC_LAST = PW'(DIV - 1);

  logic [PW-1:0] pc;

  // With DIV=1 the count stays at 0, so tick is constantly high.
  assign tick = (pc == PC_LAST);

  always_ff @(posedge clk) begin
    if (reset)     pc <= '0;
    else if (tick) pc <= '0;
    else           pc <= pc + 1'b1;
  end
endmodule

// File: rtl/led_counter.sv
// Prescaled modulo-MODULUS up-counter for an LED bank.
// Optional macro LED_COUNTER_GRAY_EN: registered Gray-coded output (needs MODULUS == 2**WIDTH).
module led_counter
  import led_counter_pkg::*;
#(
  parameter int WIDTH   = LC_WIDTH,
  parameter int MODULUS = LC_MODULUS,
  parameter int DIV     = LC_DIV
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] counter
);
  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  generate
    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
      $fatal(1, "led_counter: MODULUS %0d outside 2..2**WIDTH", MODULUS);
    end
    if (DIV < 1) begin : g_bad_div
      $fatal(1, "led_counter: DIV %0d must be >= 1", DIV);
    end
  endgenerate

  logic             tick;
  logic [WIDTH-1:0] bin;

  led_prescaler #(.DIV(DIV)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // Reset outranks tick; wrap is explicit so non-power-of-two moduli work.
  always_ff @(posedge clk) begin
    if (reset)     bin <= '0;
    else if (tick) bin <= (bin == LAST) ? '0 : bin + 1'b1;
  end

`ifdef LED_COUNTER_GRAY_EN
  generate
    if (MODULUS != (1 << WIDTH)) begin : g_bad_gray
      $fatal(1, "led_counter: Gray output requires MODULUS == 2**WIDTH");
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) counter <= '0;
    else       counter <= bin ^ (bin >> 1);
  end
`else
  assign counter = bin;
`endif
endmodule

// File: tb/tb_led_counter.sv
// Randomized and directed bench for led_counter against an arithmetic model.
`timescale 1ns/1ps
module tb_led_counter;
`ifdef LED_COUNTER_GRAY_EN
  localparam int M2 = 16;
`else
  localparam int M2 = 10;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] cnt_def, cnt_m10, cnt_d4;

  int vectors = 0;
  int miscompares = 0;

  // Model state: e = edges seen with reset low since the last reset edge.
  int e = 0;
  int e_prev = 0;
  bit rst_edge = 1'b1;

  always #2.5 clk = ~clk;

  led_counter #(.WIDTH(4), .MODULUS(16), .DIV(1)) dut_def (
    .clk(clk), .reset(reset), .counter(cnt_def));
  led_counter #(.WIDTH(4), .MODULUS(M2), .DIV(1)) dut_m10 (
    .clk(clk), .reset(reset), .counter(cnt_m10));
  led_counter #(.WIDTH(4), .MODULUS(16), .DIV(4)) dut_d4 (
    .clk(clk), .reset(reset), .counter(cnt_d4));

  // Count value = number of prescaler ticks since release, modulo MODULUS.
  function automatic logic [3:0] exp_val(input int div, input int m);
    logic [3:0] b;
`ifdef LED_COUNTER_GRAY_EN
    b = 4'((e_prev / div) % m);
    return rst_edge ? 4'd0 : (b ^ (b >> 1));
`else
    b = 4'((e / div) % m);
    return b;
`endif
  endfunction

  task automatic clk_step(input logic r);
    reset = r;
    @(posedge clk);
    e_prev = rst_edge ? 0 : e;
    rst_edge = r;
    if (r) e = 0;
    else   e = e + 1;
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 20; i++) begin
      clk_step(1'b1);
      vectors++;
      if (cnt_def !== 4'd0 || cnt_m10 !== 4'd0 || cnt_d4 !== 4'd0) begin
        miscompares++;
        $display("FAIL reset_hold edge %0d: got %0d/%0d/%0d want 0", i, cnt_def, cnt_m10, cnt_d4);
      end
    end
    for (int i = 1; i <= 44; i++) begin
      clk_step(1'b0);
      vectors++;
      if (cnt_def !== exp_val(1, 16)) begin
        miscompares++;
        $display("FAIL release edge %0d: got %0d want %0d", i, cnt_def, exp_val(1, 16));
      end
`ifndef LED_COUNTER_GRAY_EN
      if (i == 1 || i == 44) begin
        vectors++;
        if (cnt_def !== ((i == 1) ? 4'd1 : 4'd12)) begin
          miscompares++;
          $display("FAIL release_const edge %0d: got %0d want %0d", i, cnt_def, (i == 1) ? 1 : 12);
        end
      end
`endif
    end
  endtask

  task automatic test_wrap;
    clk_step(1'b1);
    for (int i = 0; i < 20; i++) begin
      clk_step(1'b0);
      vectors++;
      if (cnt_def !== exp_val(1, 16)) begin
        miscompares++;
        $display("FAIL wrap model step %0d: got %0d want %0d", i, cnt_def, exp_val(1, 16));
      end
`ifndef LED_COUNTER_GRAY_EN
      vectors++;
      if (cnt_def !== 4'((i + 1) % 16)) begin
        miscompares++;
        $display("FAIL wrap_seq step %0d: got %0d want %0d", i, cnt_def, (i + 1) % 16);
      end
`endif
    end
  endtask

  task automatic test_modulus;
    clk_step(1'b1);
    for (int i = 0; i < 35; i++) begin
      clk_step(1'b0);
      vectors++;
      if (cnt_m10 !== exp_val(1, M2)) begin
        miscompares++;
        $display("FAIL modulus step %0d: got %0d want %0d", i, cnt_m10, exp_val(1, M2));
      end
`ifndef LED_COUNTER_GRAY_EN
      vectors++;
      if (cnt_m10 > 4'd9) begin
        miscompares++;
        $display("FAIL modulus_range step %0d: got %0d want <=9", i, cnt_m10);
      end
`endif
    end
  endtask

  task automatic test_prescaler;
    int pat [8] = '{0, 0, 0, 1, 1, 1, 1, 2};
    clk_step(1'b1);
    for (int i = 0; i < 40; i++) begin
      clk_step(1'b0);
      vectors++;
      if (cnt_d4 !== exp_val(4, 16)) begin
        miscompares++;
        $display("FAIL prescaler step %0d: got %0d want %0d", i, cnt_d4, exp_val(4, 16));
      end
`ifndef LED_COUNTER_GRAY_EN
      if (i < 8) begin
        vectors++;
        if (cnt_d4 !== 4'(pat[i])) begin
          miscompares++;
          $display("FAIL prescaler_seq step %0d: got %0d want %0d", i, cnt_d4, pat[i]);
        end
      end
`endif
    end
  endtask

  task automatic test_mid_reset;
    clk_step(1'b1);
    for (int i = 0; i < 7; i++) clk_step(1'b0);
`ifndef LED_COUNTER_GRAY_EN
    vectors++;
    if (cnt_def !== 4'd7) begin
      miscompares++;
      $display("FAIL mid_reset_pre: got %0d want 7", cnt_def);
    end
`endif
    clk_step(1'b1);
    vectors++;
    if (cnt_def !== 4'd0) begin
      miscompares++;
      $display("FAIL mid_reset_clear: got %0d want 0", cnt_def);
    end
    clk_step(1'b0);
    vectors++;
    if (cnt_def !== exp_val(1, 16)) begin
      miscompares++;
      $display("FAIL mid_reset_resume: got %0d want %0d", cnt_def, exp_val(1, 16));
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 600; i++) begin
      clk_step(($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0);
      vectors++;
      if (cnt_def !== exp_val(1, 16) || cnt_m10 !== exp_val(1, M2) || cnt_d4 !== exp_val(4, 16)) begin
        miscompares++;
        $display("FAIL random step %0d: got %0d/%0d/%0d want %0d/%0d/%0d", i,
                 cnt_def, cnt_m10, cnt_d4, exp_val(1, 16), exp_val(1, M2), exp_val(4, 16));
      end
    end
  endtask

`ifdef LED_COUNTER_GRAY_EN
  task automatic test_gray;
    int tbl [9] = '{0, 1, 3, 2, 6, 7, 5, 4, 12};
    logic [3:0] prev;
    clk_step(1'b1);
    clk_step(1'b0);
    prev = cnt_def;
    for (int k = 2; k < 40; k++) begin
      clk_step(1'b0);
      vectors++;
      if ($countones(prev ^ cnt_def) != 1) begin
        miscompares++;
        $display("FAIL gray_onebit step %0d: got %b after %b want one bit change", k, cnt_def, prev);
      end
      if (k <= 9) begin
        vectors++;
        if (cnt_def !== 4'(tbl[k-1])) begin
          miscompares++;
          $display("FAIL gray_seq step %0d: got %0d want %0d", k, cnt_def, tbl[k-1]);
        end
      end
      prev = cnt_def;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_wrap();
    test_modulus();
    test_prescaler();
    test_mid_reset();
    test_random();
`ifdef LED_COUNTER_GRAY_EN
    test_gray();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
